// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush controller for the 5-stage pipeline with memory handshake, watchdog and stall counter
module pipeline_ctrl #(
  parameter int TIMEOUT = 8,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             MemRead_EX,
  input  logic [4:0]       wrin_EX,
  input  logic [4:0]       rs_ID,
  input  logic [4:0]       rt_ID,
  input  logic             rt_used_ID,
  input  logic             branch_taken_EX,
  input  logic             MemRead_MEM,
  input  logic             MemWrite_MEM,
  input  logic             mem_ready,
  output logic             en_PC,
  output logic             en_IF_ID,
  output logic             en_ID_EX,
  output logic             en_EX_MEM,
  output logic             en_MEM_WB,
  output logic             flush_IF_ID,
  output logic             bubble_ID_EX,
  output logic             bubble_MEM_WB,
  output logic             mem_req,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count
);
  localparam int WW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {RUN, WAIT, ERR} state_t;
  state_t state, state_nx;
  logic [WW-1:0] wait_cnt, wait_nx;
  logic timeout_nx, acc, err, mstall, br, hz, lu;
  always_comb begin
    acc = MemRead_MEM | MemWrite_MEM;
    err = state == ERR;
    mstall = !mem_ready && ((state == RUN && acc) || state == WAIT);
    br = !err && !mstall && branch_taken_EX;
    hz = MemRead_EX && wrin_EX != '0 && (wrin_EX == rs_ID || (rt_used_ID && wrin_EX == rt_ID));
    lu = !err && !mstall && !branch_taken_EX && hz;
    en_PC = !(err || mstall || lu);
    en_IF_ID = !(err || mstall || lu);
    en_ID_EX = !(err || mstall);
    en_EX_MEM = !(err || mstall);
    en_MEM_WB = !err;
    flush_IF_ID = br;
    bubble_ID_EX = br || lu;
    bubble_MEM_WB = mstall;
    mem_req = acc && !err;
    state_nx = state;
    wait_nx = wait_cnt;
    timeout_nx = mem_timeout;
    if (state == RUN && mstall) begin
      state_nx = WAIT;
      wait_nx = '0;
    end else if (state == WAIT && mem_ready) begin
      state_nx = RUN;
    end else if (state == WAIT && wait_cnt == WW'(TIMEOUT - 1)) begin
      state_nx = ERR;
      timeout_nx = 1'b1;
    end else if (state == WAIT) begin
      wait_nx = wait_cnt + WW'(1);
    end
  end
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= RUN;
      wait_cnt <= '0;
      mem_timeout <= 1'b0;
      stall_count <= '0;
    end else begin
      state <= state_nx;
      wait_cnt <= wait_nx;
      mem_timeout <= timeout_nx;
      if (!en_PC && stall_count != '1) stall_count <= stall_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed scenarios plus randomized run against a request-age reference model
module tb_pipeline_ctrl;
  localparam int TO = 4;
  localparam int CW = 4;
  localparam logic [8:0] DEF = 9'b111110000;
  localparam logic [8:0] LU = 9'b001110100;
  localparam logic [8:0] BR = 9'b111111100;
  localparam logic [8:0] MST = 9'b000010011;
  localparam logic [8:0] REL = 9'b111110001;
  logic CLK = 0, RESET_N = 0;
  logic MemRead_EX = 0, rt_used_ID = 0, branch_taken_EX = 0;
  logic MemRead_MEM = 0, MemWrite_MEM = 0, mem_ready = 0;
  logic [4:0] wrin_EX = 0, rs_ID = 0, rt_ID = 0;
  logic en_PC, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB;
  logic flush_IF_ID, bubble_ID_EX, bubble_MEM_WB, mem_req, mem_timeout;
  logic [CW-1:0] stall_count;
  int checks = 0, errors = 0;
  bit m_err, m_to;
  int m_age, m_stall;

  pipeline_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .MemRead_EX(MemRead_EX), .wrin_EX(wrin_EX),
    .rs_ID(rs_ID), .rt_ID(rt_ID), .rt_used_ID(rt_used_ID), .branch_taken_EX(branch_taken_EX),
    .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM), .mem_ready(mem_ready),
    .en_PC(en_PC), .en_IF_ID(en_IF_ID), .en_ID_EX(en_ID_EX), .en_EX_MEM(en_EX_MEM),
    .en_MEM_WB(en_MEM_WB), .flush_IF_ID(flush_IF_ID), .bubble_ID_EX(bubble_ID_EX),
    .bubble_MEM_WB(bubble_MEM_WB), .mem_req(mem_req), .mem_timeout(mem_timeout),
    .stall_count(stall_count)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 1000000", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [8:0] outs();
    return {en_PC, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB, flush_IF_ID, bubble_ID_EX, bubble_MEM_WB, mem_req};
  endfunction

  // Age counts prior unready cycles of the current access; an access is hung once it has waited TIMEOUT+1 cycles.
  function automatic bit m_stalled();
    return !m_err && !mem_ready && (m_age > 0 || MemRead_MEM || MemWrite_MEM);
  endfunction

  function automatic logic [8:0] exp_out();
    bit ms, br, lu, hz;
    ms = m_stalled();
    hz = MemRead_EX && wrin_EX != 0 && (wrin_EX == rs_ID || (rt_used_ID && wrin_EX == rt_ID));
    br = !m_err && !ms && branch_taken_EX;
    lu = !m_err && !ms && !branch_taken_EX && hz;
    return {!(m_err || ms || lu), !(m_err || ms || lu), !(m_err || ms), !(m_err || ms), !m_err,
            br, br || lu, ms, (MemRead_MEM || MemWrite_MEM) && !m_err};
  endfunction

  task automatic set_in(input logic mr_ex, input logic [4:0] wr, input logic [4:0] rs, input logic [4:0] rt,
                        input logic rtu, input logic br, input logic mrm, input logic mwm, input logic rdy);
    MemRead_EX = mr_ex; wrin_EX = wr; rs_ID = rs; rt_ID = rt; rt_used_ID = rtu;
    branch_taken_EX = br; MemRead_MEM = mrm; MemWrite_MEM = mwm; mem_ready = rdy;
    #1;
  endtask

  task automatic tick();
    logic [8:0] e;
    bit ms;
    e = exp_out();
    ms = m_stalled();
    @(posedge CLK);
    if (!e[8] && m_stall < (1 << CW) - 1) m_stall++;
    if (ms && m_age == TO) begin
      m_err = 1; m_to = 1;
    end else m_age = ms ? m_age + 1 : 0;
    @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET_N = 0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    m_err = 0; m_to = 0; m_age = 0; m_stall = 0;
    @(negedge CLK);
    RESET_N = 1;
  endtask

  task automatic test_reset();
    RESET_N = 0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (outs() !== DEF) begin errors++; $display("FAIL reset_outs: got %b required %b", outs(), DEF); end
    checks++;
    if (stall_count !== 0 || mem_timeout !== 0) begin
      errors++; $display("FAIL reset_regs: got cnt=%0d to=%b required cnt=0 to=0", stall_count, mem_timeout);
    end
    do_reset();
  endtask

  task automatic test_load_use();
    do_reset();
    set_in(1, 5, 5, 0, 0, 0, 0, 0, 0);
    checks++;
    if (outs() !== LU) begin errors++; $display("FAIL load_use_rs: got %b required %b", outs(), LU); end
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (stall_count !== 1 || outs() !== DEF) begin
      errors++; $display("FAIL load_use_one_cycle: got cnt=%0d outs=%b required cnt=1 outs=%b", stall_count, outs(), DEF);
    end
    set_in(1, 0, 0, 0, 1, 0, 0, 0, 0);
    checks++;
    if (outs() !== DEF) begin errors++; $display("FAIL load_use_r0: got %b required %b", outs(), DEF); end
    set_in(1, 7, 1, 7, 1, 0, 0, 0, 0);
    checks++;
    if (outs() !== LU) begin errors++; $display("FAIL load_use_rt: got %b required %b", outs(), LU); end
    set_in(1, 7, 1, 7, 0, 0, 0, 0, 0);
    checks++;
    if (outs() !== DEF) begin errors++; $display("FAIL load_use_rt_unused: got %b required %b", outs(), DEF); end
    tick();
    checks++;
    if (stall_count !== 1) begin errors++; $display("FAIL load_use_count: got %0d required 1", stall_count); end
  endtask

  task automatic test_branch();
    do_reset();
    set_in(1, 5, 5, 0, 0, 1, 0, 0, 0);
    checks++;
    if (outs() !== BR) begin errors++; $display("FAIL branch_over_lu: got %b required %b", outs(), BR); end
    tick();
    checks++;
    if (stall_count !== 0) begin errors++; $display("FAIL branch_count: got %0d required 0", stall_count); end
  endtask

  task automatic test_three_wait();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(i == 1, 5, 5, 0, 0, i == 2, 1, 0, 0);
      checks++;
      if (outs() !== MST) begin errors++; $display("FAIL wait3_stall%0d: got %b required %b", i, outs(), MST); end
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 1);
    checks++;
    if (outs() !== REL) begin errors++; $display("FAIL wait3_release: got %b required %b", outs(), REL); end
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (outs() !== DEF || stall_count !== 3) begin
      errors++; $display("FAIL wait3_after: got outs=%b cnt=%0d required outs=%b cnt=3", outs(), stall_count, DEF);
    end
  endtask

  task automatic test_zero_wait();
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
    checks++;
    if (outs() !== REL) begin errors++; $display("FAIL zero_wait: got %b required %b", outs(), REL); end
    tick();
    set_in(0, 0, 0, 0, 0, 1, 0, 0, 0);
    checks++;
    if (outs() !== BR || stall_count !== 0) begin
      errors++; $display("FAIL zero_wait_after: got outs=%b cnt=%0d required outs=%b cnt=0", outs(), stall_count, BR);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < TO + 1; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
      checks++;
      if (outs() !== MST || mem_timeout !== 0) begin
        errors++; $display("FAIL timeout_req%0d: got outs=%b to=%b required outs=%b to=0", i, outs(), mem_timeout, MST);
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      set_in(i == 1, 5, 5, 0, 0, i == 2, 1, 0, i == 0);
      checks++;
      if (outs() !== 9'b0 || mem_timeout !== 1) begin
        errors++; $display("FAIL timeout_err%0d: got outs=%b to=%b required outs=000000000 to=1", i, outs(), mem_timeout);
      end
      tick();
    end
    do_reset();
    checks++;
    if (mem_timeout !== 0 || outs() !== DEF) begin
      errors++; $display("FAIL timeout_cleared: got to=%b outs=%b required to=0 outs=%b", mem_timeout, outs(), DEF);
    end
    for (int i = 0; i < TO; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 1);
    checks++;
    if (outs() !== REL) begin errors++; $display("FAIL late_ready: got %b required %b", outs(), REL); end
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (mem_timeout !== 0 || outs() !== DEF || stall_count !== TO) begin
      errors++; $display("FAIL late_ready_after: got to=%b outs=%b cnt=%0d required to=0 outs=%b cnt=%0d",
                         mem_timeout, outs(), stall_count, DEF, TO);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
      tick();
    end
    RESET_N = 0;
    #1;
    checks++;
    if (stall_count !== 0 || mem_timeout !== 0 || outs() !== MST) begin
      errors++; $display("FAIL reset_mid_wait: got cnt=%0d to=%b outs=%b required cnt=0 to=0 outs=%b",
                         stall_count, mem_timeout, outs(), MST);
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (outs() !== DEF) begin errors++; $display("FAIL reset_mid_wait_req: got %b required %b", outs(), DEF); end
    @(negedge CLK);
    RESET_N = 1;
    m_err = 0; m_to = 0; m_age = 0; m_stall = 0;
    tick();
    checks++;
    if (outs() !== DEF || mem_timeout !== 0) begin
      errors++; $display("FAIL reset_mid_wait_run: got outs=%b to=%b required outs=%b to=0", outs(), mem_timeout, DEF);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      set_in(1, 9, 9, 0, 0, 0, 0, 0, 0);
      tick();
      if (i == 14 || i == 15 || i == 20) begin
        checks++;
        if (stall_count !== CW'(i > 15 ? 15 : i)) begin
          errors++; $display("FAIL saturate_%0d: got %0d required %0d", i, stall_count, i > 15 ? 15 : i);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [8:0] e;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (m_err && $urandom_range(0, 3) == 0) do_reset();
      set_in($urandom_range(0, 1), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             $urandom_range(0, 1), $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0);
      e = exp_out();
      checks++;
      if (outs() !== e) begin errors++; $display("FAIL rand_outs@%0d: got %b required %b", i, outs(), e); end
      tick();
      checks++;
      if (stall_count !== CW'(m_stall) || mem_timeout !== m_to) begin
        errors++; $display("FAIL rand_regs@%0d: got cnt=%0d to=%b required cnt=%0d to=%b",
                           i, stall_count, mem_timeout, m_stall, m_to);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_three_wait();
    test_zero_wait();
    test_timeout();
    test_reset_mid_wait();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
